// File: rtl/hazard_controller_if.sv
// Pipeline-side bundle of the hazard controller. The pipeline drives the
// hazard inputs and consumes the enables. The controller drives the enables
// and the debug counters.
interface hazard_controller_if #(
    parameter int CNT_WIDTH = 32
);
    logic [4:0]           ID_rs1;
    logic [4:0]           ID_rs2;
    logic                 ID_use_rs1;
    logic                 ID_use_rs2;
    logic [4:0]           ID_EX_rd;
    logic                 ID_EX_mem_read;
    logic                 EX_redirect;
    logic                 EX_MEM_mem_req;
    logic                 dmem_ack;
    logic                 PC_write;
    logic                 IF_ID_write;
    logic                 ID_EX_write;
    logic                 EX_MEM_write;
    logic                 IF_ID_flush;
    logic                 ID_EX_flush;
    logic                 MEM_WB_flush;
    logic [CNT_WIDTH-1:0] stall_cycles;
    logic [CNT_WIDTH-1:0] flush_events;
    logic                 mem_timeout;

    modport master (
        output ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, ID_EX_rd, ID_EX_mem_read,
               EX_redirect, EX_MEM_mem_req, dmem_ack,
        input  PC_write, IF_ID_write, ID_EX_write, EX_MEM_write,
               IF_ID_flush, ID_EX_flush, MEM_WB_flush,
               stall_cycles, flush_events, mem_timeout
    );

    modport slave (
        input  ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, ID_EX_rd, ID_EX_mem_read,
               EX_redirect, EX_MEM_mem_req, dmem_ack,
        output PC_write, IF_ID_write, ID_EX_write, EX_MEM_write,
               IF_ID_flush, ID_EX_flush, MEM_WB_flush,
               stall_cycles, flush_events, mem_timeout
    );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller for the 5-stage core.
// Memory stall outranks an EX redirect, and a redirect outranks a load-use
// bubble. The control enables are combinational. The FSM, the counters and
// the timeout flag are registered.
module hazard_controller #(
    parameter int CNT_WIDTH   = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rstn,
    hazard_controller_if.slave hz
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W:0]      TIMEOUT_LIM = (WAIT_W + 1)'(MEM_TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [WAIT_W:0]      wait_inc_s;
    logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_WIDTH-1:0] flush_events_q, flush_events_d;
    logic                 mem_timeout_q, mem_timeout_d;

    logic mem_stall_s, redirect_s, load_use_s, rs_match_s;
    logic pc_write_s, if_id_write_s, id_ex_write_s, ex_mem_write_s;
    logic if_id_flush_s, id_ex_flush_s, mem_wb_flush_s;

    // Hazard classification, already ranked by priority.
    always_comb begin
        mem_stall_s = ((state_q == MEM_WAIT) && !hz.dmem_ack) ||
                      ((state_q == RUN) && hz.EX_MEM_mem_req && !hz.dmem_ack);
        rs_match_s  = (hz.ID_use_rs1 && (hz.ID_rs1 == hz.ID_EX_rd)) ||
                      (hz.ID_use_rs2 && (hz.ID_rs2 == hz.ID_EX_rd));
        redirect_s  = !mem_stall_s && hz.EX_redirect;
        load_use_s  = !mem_stall_s && !hz.EX_redirect && hz.ID_EX_mem_read &&
                      (hz.ID_EX_rd != 5'd0) && rs_match_s;
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Timeout never forces the FSM out of MEM_WAIT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      state_d = (hz.EX_MEM_mem_req && !hz.dmem_ack) ? MEM_WAIT : RUN;
            MEM_WAIT: state_d = hz.dmem_ack ? RUN : MEM_WAIT;
            default:  state_d = RUN;
        endcase
    end

    // Pipeline enables. The three hazard cases are handled in priority order.
    always_comb begin
        pc_write_s     = 1'b1;
        if_id_write_s  = 1'b1;
        id_ex_write_s  = 1'b1;
        ex_mem_write_s = 1'b1;
        if_id_flush_s  = 1'b0;
        id_ex_flush_s  = 1'b0;
        mem_wb_flush_s = 1'b0;
        if (mem_stall_s) begin
            pc_write_s     = 1'b0;
            if_id_write_s  = 1'b0;
            id_ex_write_s  = 1'b0;
            ex_mem_write_s = 1'b0;
            mem_wb_flush_s = 1'b1;
        end else if (redirect_s) begin
            if_id_flush_s  = 1'b1;
            id_ex_flush_s  = 1'b1;
        end else if (load_use_s) begin
            pc_write_s     = 1'b0;
            if_id_write_s  = 1'b0;
            id_ex_flush_s  = 1'b1;
        end else begin
            pc_write_s     = 1'b1;
        end
    end

    // Saturating debug counters, the MEM_WAIT cycle counter and the sticky timeout flag.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        wait_cnt_d     = wait_cnt_q;
        mem_timeout_d  = mem_timeout_q;
        wait_inc_s     = {1'b0, wait_cnt_q} + {{WAIT_W{1'b0}}, 1'b1};
        if (!pc_write_s && (stall_cycles_q != CNT_MAX)) begin
            stall_cycles_d = stall_cycles_q + CNT_ONE;
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
        if (redirect_s && (flush_events_q != CNT_MAX)) begin
            flush_events_d = flush_events_q + CNT_ONE;
        end else begin
            flush_events_d = flush_events_q;
        end
        case (state_q)
            RUN: begin
                // The counter sits at zero in RUN, so it is clear on entry to MEM_WAIT.
                wait_cnt_d = {WAIT_W{1'b0}};
            end
            MEM_WAIT: begin
                if (!hz.dmem_ack) begin
                    if (wait_inc_s <= TIMEOUT_LIM) begin
                        wait_cnt_d = wait_inc_s[WAIT_W-1:0];
                    end else begin
                        wait_cnt_d = wait_cnt_q;
                    end
                    if (wait_inc_s >= TIMEOUT_LIM) begin
                        mem_timeout_d = 1'b1;
                    end else begin
                        mem_timeout_d = mem_timeout_q;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q;
                end
            end
            default: wait_cnt_d = {WAIT_W{1'b0}};
        endcase
    end

    // Counter and timeout registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cycles_q <= {CNT_WIDTH{1'b0}};
            flush_events_q <= {CNT_WIDTH{1'b0}};
            wait_cnt_q     <= {WAIT_W{1'b0}};
            mem_timeout_q  <= 1'b0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_timeout_q  <= mem_timeout_d;
        end
    end

    assign hz.PC_write     = pc_write_s;
    assign hz.IF_ID_write  = if_id_write_s;
    assign hz.ID_EX_write  = id_ex_write_s;
    assign hz.EX_MEM_write = ex_mem_write_s;
    assign hz.IF_ID_flush  = if_id_flush_s;
    assign hz.ID_EX_flush  = id_ex_flush_s;
    assign hz.MEM_WB_flush = mem_wb_flush_s;
    assign hz.stall_cycles = stall_cycles_q;
    assign hz.flush_events = flush_events_q;
    assign hz.mem_timeout  = mem_timeout_q;
endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller. It uses combinational vectors under
// reset and hand-built multi-cycle sequences for memory wait, priority,
// timeout, reset and saturation.
module tb_hazard_controller;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    hazard_controller_if #(.CNT_WIDTH(4)) hz ();

    hazard_controller #(.CNT_WIDTH(4), .MEM_TIMEOUT(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .hz   (hz)
    );

    always #5 clk = ~clk;

    // ctl packing: {PC_w, IF_ID_w, ID_EX_w, EX_MEM_w, IF_ID_f, ID_EX_f, MEM_WB_f}
    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, mr, redir, req, ack;
        logic [6:0] exp_ctl;
    } vec_t;

    vec_t vecs[13];

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic mr, input logic redir, input logic req,
                          input logic ack);
        hz.ID_rs1 = rs1;  hz.ID_rs2 = rs2;
        hz.ID_use_rs1 = u1; hz.ID_use_rs2 = u2;
        hz.ID_EX_rd = rd; hz.ID_EX_mem_read = mr;
        hz.EX_redirect = redir; hz.EX_MEM_mem_req = req; hz.dmem_ack = ack;
    endtask

    task automatic zero_in();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_ctl(input string name, input logic [6:0] exp);
        #1;
        chk(name, {25'd0, hz.PC_write, hz.IF_ID_write, hz.ID_EX_write, hz.EX_MEM_write,
                   hz.IF_ID_flush, hz.ID_EX_flush, hz.MEM_WB_flush}, {25'd0, exp});
    endtask

    // Advance one clock and land just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        zero_in();
        @(negedge clk);
        rstn = 1'b1;
        step();
    endtask

    initial begin
        //            rs1    rs2    rd     u1    u2    mr    redir req   ack   ctl
        vecs[0]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1111_000};
        vecs[1]  = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0011_010};
        vecs[2]  = '{5'd0, 5'd7, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0011_010};
        vecs[3]  = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1111_000};
        vecs[4]  = '{5'd0, 5'd5, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1111_000};
        vecs[5]  = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1111_000};
        vecs[6]  = '{5'd3, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1111_000};
        vecs[7]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'b1111_110};
        vecs[8]  = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7'b1111_110};
        vecs[9]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'b0000_001};
        vecs[10] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 7'b0000_001};
        vecs[11] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'b1111_000};
        vecs[12] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 7'b0011_010};

        zero_in();
        #2;
        chk_ctl("reset_ctl", 7'b1111_000);
        chk("reset_stall_cnt", {28'd0, hz.stall_cycles}, 32'd0);
        chk("reset_flush_cnt", {28'd0, hz.flush_events}, 32'd0);
        chk("reset_timeout", {31'd0, hz.mem_timeout}, 32'd0);

        // Combinational decode is checked while reset holds the FSM in RUN.
        for (int i = 0; i < 13; i++) begin
            set_in(vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].rd,
                   vecs[i].mr, vecs[i].redir, vecs[i].req, vecs[i].ack);
            chk_ctl($sformatf("vec%0d", i), vecs[i].exp_ctl);
        end

        // Load-use inserts one bubble; the next cycle forwarding covers it.
        do_reset();
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_ctl("lu_stall", 7'b0011_010);
        step();
        zero_in();
        chk_ctl("lu_release", 7'b1111_000);
        chk("lu_stall_cnt", {28'd0, hz.stall_cycles}, 32'd1);

        // Memory wait: ack three cycles after the request, then a back-to-back request.
        do_reset();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_ctl("mw_c0", 7'b0000_001);
        step();
        chk_ctl("mw_c1", 7'b0000_001);
        step();
        chk_ctl("mw_c2", 7'b0000_001);
        step();
        hz.dmem_ack = 1'b1;
        chk_ctl("mw_ack", 7'b1111_000);
        step();
        hz.dmem_ack = 1'b0;
        chk("mw_stall_cnt", {28'd0, hz.stall_cycles}, 32'd3);
        chk_ctl("mw_reenter", 7'b0000_001);
        step();
        hz.dmem_ack = 1'b1;
        chk_ctl("mw_ack2", 7'b1111_000);
        step();
        zero_in();
        chk_ctl("mw_idle", 7'b1111_000);
        chk("mw_stall_cnt2", {28'd0, hz.stall_cycles}, 32'd4);

        // A request acked in the same cycle costs nothing.
        do_reset();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk_ctl("same_ack", 7'b1111_000);
        step();
        zero_in();
        chk_ctl("same_ack_idle", 7'b1111_000);
        chk("same_ack_cnt", {28'd0, hz.stall_cycles}, 32'd0);

        // Redirect beats load-use.
        do_reset();
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_ctl("redir_lu", 7'b1111_110);
        step();
        zero_in();
        chk("redir_flush_cnt", {28'd0, hz.flush_events}, 32'd1);
        chk("redir_stall_cnt", {28'd0, hz.stall_cycles}, 32'd0);

        // Redirect held through MEM_WAIT is applied once the stall releases.
        do_reset();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk_ctl("rmw_c0", 7'b0000_001);
        step();
        chk_ctl("rmw_c1", 7'b0000_001);
        step();
        chk("rmw_flush_sup", {28'd0, hz.flush_events}, 32'd0);
        hz.dmem_ack = 1'b1;
        chk_ctl("rmw_release", 7'b1111_110);
        step();
        zero_in();
        chk("rmw_flush_cnt", {28'd0, hz.flush_events}, 32'd1);
        chk("rmw_stall_cnt", {28'd0, hz.stall_cycles}, 32'd2);

        // Timeout sets after four MEM_WAIT cycles and is sticky past the ack.
        do_reset();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (4) step();
        chk("to_not_yet", {31'd0, hz.mem_timeout}, 32'd0);
        step();
        chk("to_set", {31'd0, hz.mem_timeout}, 32'd1);
        chk_ctl("to_still_wait", 7'b0000_001);
        hz.dmem_ack = 1'b1;
        chk_ctl("to_ack", 7'b1111_000);
        step();
        zero_in();
        step();
        chk("to_sticky", {31'd0, hz.mem_timeout}, 32'd1);
        chk("to_stall_cnt", {28'd0, hz.stall_cycles}, 32'd5);

        // Asynchronous reset in the middle of MEM_WAIT.
        do_reset();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (6) step();
        #2;
        rstn = 1'b0;
        zero_in();
        #1;
        chk("rst_mid_timeout", {31'd0, hz.mem_timeout}, 32'd0);
        chk("rst_mid_stall_cnt", {28'd0, hz.stall_cycles}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        step();
        chk_ctl("rst_mid_run", 7'b1111_000);
        chk("rst_mid_stall_cnt2", {28'd0, hz.stall_cycles}, 32'd0);

        // Saturation of the 4-bit stall counter.
        do_reset();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (14) step();
        chk("sat_14", {28'd0, hz.stall_cycles}, 32'd14);
        step();
        chk("sat_15", {28'd0, hz.stall_cycles}, 32'd15);
        repeat (5) step();
        chk("sat_20", {28'd0, hz.stall_cycles}, 32'd15);
        zero_in();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
